// File: rtl/vliw_mem_pkg.sv
// rtl/vliw_mem_pkg.sv - shared types, constants and byte-merge helper for banked_main_memory
package vliw_mem_pkg;

    typedef enum logic [0:0] {
        MEM_INIT = 1'b0,
        MEM_RUN  = 1'b1
    } mem_state_e;

    localparam int BYTE_W = 8;

    // Widest word the merge helper handles; callers zero-extend in and truncate out.
    localparam int MAX_W  = 1024;
    localparam int MAX_BE = MAX_W / BYTE_W;

    // Byte i of the result comes from new_w where be[i] is set, otherwise from old_w.
    function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_w,
                                                  input logic [MAX_W-1:0]  new_w,
                                                  input logic [MAX_BE-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - LAT-stage delay line for read {valid, err, data} with synchronous flush
module mem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    input  logic              s_terr,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    output logic              m_terr,
    output logic [DATA_W-1:0] m_tdata
);

    localparam int W = DATA_W + 2;

    logic [W-1:0] stage_q [LAT];
    logic [W-1:0] stage_d [LAT];

    // Each stage takes the previous one; stage 0 takes the freshly accepted read.
    always_comb begin
        stage_d[0] = {s_tvalid, s_terr, s_tdata};
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset empties every stage so in-flight reads never return.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            if (!rst_n) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign {m_tvalid, m_terr, m_tdata} = stage_q[LAT-1];

endmodule

// File: rtl/banked_main_memory.sv
// rtl/banked_main_memory.sv - byte-strobed write, NUM_RD pipelined read ports, zero-fill after reset
module banked_main_memory
    import vliw_mem_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 256,
    parameter int ADDR_W        = 32,
    parameter int NUM_RD        = 2,
    parameter int RD_LAT        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     init_done,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    output logic                     wr_err,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_err
);

    localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]  DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              wr_err_q, wr_err_d;

    logic              wr_in_range;
    logic              wr_hit;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    // Fill sequencing, write acceptance and the array write port.
    always_comb begin
        wr_in_range = wr_addr < DEPTH_A;
        wr_hit      = (state_q == MEM_RUN) && wr_en && wr_in_range;
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_err_d    = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = wr_addr[IDX_W-1:0];
        mem_wdata   = DATA_W'(be_merge(MAX_W'(mem[mem_widx]), MAX_W'(wr_data), MAX_BE'(wr_be)));
        case (state_q)
            MEM_INIT: begin
                mem_we    = 1'b1;
                mem_widx  = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = MEM_RUN;
                end
            end
            MEM_RUN: begin
                mem_we   = wr_hit;
                wr_err_d = wr_en && !wr_in_range;
            end
            default: state_d = MEM_RUN;
        endcase
        init_done_d = (state_d == MEM_RUN);
    end

    // Control state; reset restarts the fill from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (INIT_ON_RESET != 0) ? MEM_INIT : MEM_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Storage array; contents survive reset and are only cleared by the fill.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign init_done = init_done_q;
    assign wr_err    = wr_err_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              in_range;
        logic              acc;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] word_out;

        // Array lookup with write-first forwarding of a same-cycle write to the same word.
        always_comb begin
            addr     = rd_addr[p*ADDR_W +: ADDR_W];
            in_range = addr < DEPTH_A;
            acc      = (state_q == MEM_RUN) && rd_en[p];
            word     = mem[addr[IDX_W-1:0]];
            if (wr_hit && (wr_addr == addr)) begin
                word = DATA_W'(be_merge(MAX_W'(word), MAX_W'(wr_data), MAX_BE'(wr_be)));
            end
            word_out = (acc && in_range) ? word : '0;
        end

        mem_rd_pipe #(
            .DATA_W (DATA_W),
            .LAT    (RD_LAT)
        ) u_rd_pipe (
            .clk      (clk),
            .rst_n    (rst_n),
            .s_tvalid (acc),
            .s_terr   (acc && !in_range),
            .s_tdata  (word_out),
            .m_tvalid (rd_valid[p]),
            .m_terr   (rd_err[p]),
            .m_tdata  (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_banked_main_memory.sv
// tb/tb_banked_main_memory.sv - directed self-checking bench for banked_main_memory
module tb_banked_main_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         init_done_a;
    logic         wr_en_a;
    logic [31:0]  wr_addr_a;
    logic [31:0]  wr_data_a;
    logic [3:0]   wr_be_a;
    logic         wr_err_a;
    logic [3:0]   rd_en_a;
    logic [127:0] rd_addr_a;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_valid_a;
    logic [3:0]   rd_err_a;

    logic         init_done_b;
    logic         wr_en_b;
    logic [7:0]   wr_addr_b;
    logic [31:0]  wr_data_b;
    logic [3:0]   wr_be_b;
    logic         wr_err_b;
    logic [0:0]   rd_en_b;
    logic [7:0]   rd_addr_b;
    logic [31:0]  rd_data_b;
    logic [0:0]   rd_valid_b;
    logic [0:0]   rd_err_b;

    banked_main_memory #(
        .DATA_W(32), .DEPTH(256), .ADDR_W(32), .NUM_RD(4), .RD_LAT(3), .INIT_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .init_done(init_done_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_be(wr_be_a), .wr_err(wr_err_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a)
    );

    banked_main_memory #(
        .DATA_W(32), .DEPTH(10), .ADDR_W(8), .NUM_RD(1), .RD_LAT(1), .INIT_ON_RESET(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .init_done(init_done_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_be(wr_be_b), .wr_err(wr_err_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle;
        rd_en_a = '0;
        wr_en_a = 1'b0;
    endtask

    task automatic a_rd(input int p, input logic [31:0] addr);
        rd_en_a[p] = 1'b1;
        rd_addr_a[p*32 +: 32] = addr;
    endtask

    task automatic a_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en_a   = 1'b1;
        wr_addr_a = addr;
        wr_data_a = data;
        wr_be_a   = be;
    endtask

    // Accept whatever is driven, clear inputs, then wait until the read pipeline output is visible.
    task automatic a_go;
        tick;
        a_idle;
        repeat (2) tick;
    endtask

    int   n;
    logic seen;
    logic before_rst;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_idle;
        wr_addr_a = '0; wr_data_a = '0; wr_be_a = '0; rd_addr_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0;
        rd_en_b = '0; rd_addr_b = '0;
        tick;
        tick;
        chk("rst_init_done", 128'(init_done_a), 128'd0);
        chk("rst_rd_valid", 128'(rd_valid_a), 128'd0);
        chk("rst_wr_err", 128'(wr_err_a), 128'd0);
        chk("rst_rd_data", rd_data_a, 128'd0);

        // Fill: requests during MEM_INIT must be ignored.
        rst_n = 1'b1;
        rd_en_a = 4'hF;
        a_wr(32'd0, 32'hFFFF_FFFF, 4'hF);
        n = 0;
        seen = 1'b0;
        while (!init_done_a && n < 1000) begin
            tick;
            n++;
            if (n == 1) chk("b_init_done_first", 128'(init_done_b), 128'd1);
            seen = seen | (|rd_valid_a) | wr_err_a;
        end
        a_idle;
        chk("init_cycles", 128'(n), 128'd256);
        repeat (3) begin
            tick;
            seen = seen | (|rd_valid_a);
        end
        chk("init_ignored", 128'(seen), 128'd0);

        // Zero-filled words at 0, 128, 255; valid exactly at RD_LAT.
        a_rd(0, 32'd0); a_rd(1, 32'd128); a_rd(2, 32'd255);
        tick;
        a_idle;
        tick;
        chk("early_valid", 128'(rd_valid_a), 128'd0);
        tick;
        chk("fill_valid", 128'(rd_valid_a), 128'h7);
        chk("fill_data", rd_data_a, 128'd0);
        chk("fill_err", 128'(rd_err_a), 128'd0);
        tick;
        chk("valid_one_cycle", 128'(rd_valid_a), 128'd0);

        // Byte-strobed partial write.
        a_wr(32'd5, 32'hDEAD_BEEF, 4'hF); tick; a_idle;
        a_wr(32'd5, 32'h1122_3344, 4'b0101); tick; a_idle;
        a_rd(0, 32'd5);
        a_go;
        chk("be_merge_data", 128'(rd_data_a[31:0]), 128'h DE22_BE44);
        chk("be_merge_valid", 128'(rd_valid_a), 128'h1);

        // Write-first forwarding, full and partial.
        a_wr(32'd9, 32'hCAFE_F00D, 4'hF); a_rd(1, 32'd9);
        a_go;
        chk("fwd_full", 128'(rd_data_a[63:32]), 128'hCAFE_F00D);
        a_wr(32'd9, 32'h1234_5678, 4'b1000); a_rd(2, 32'd9);
        a_go;
        chk("fwd_partial", 128'(rd_data_a[95:64]), 128'h12FE_F00D);

        // A write after the read issues must not change the returned data.
        a_rd(0, 32'd9);
        tick;
        a_idle;
        a_wr(32'd9, 32'h0, 4'hF);
        tick;
        a_idle;
        tick;
        chk("late_write", 128'(rd_data_a[31:0]), 128'h12FE_F00D);

        // Out-of-range read and write.
        a_rd(0, 32'd300); a_wr(32'd256, 32'hDEAD_BEEF, 4'hF);
        tick;
        a_idle;
        chk("wr_err_pulse", 128'(wr_err_a), 128'd1);
        tick;
        chk("wr_err_single", 128'(wr_err_a), 128'd0);
        tick;
        chk("oor_valid", 128'(rd_valid_a), 128'h1);
        chk("oor_err", 128'(rd_err_a), 128'h1);
        chk("oor_data", 128'(rd_data_a[31:0]), 128'd0);
        a_rd(0, 32'd0);
        a_go;
        chk("addr0_untouched", 128'(rd_data_a[31:0]), 128'd0);

        // Upper address bits must not be dropped.
        a_rd(3, 32'h1000_0005);
        a_go;
        chk("wide_rd_err", 128'(rd_err_a), 128'h8);
        chk("wide_rd_data", 128'(rd_data_a[127:96]), 128'd0);
        a_wr(32'h0100_0007, 32'hFFFF_FFFF, 4'hF);
        tick;
        a_idle;
        chk("wide_wr_err", 128'(wr_err_a), 128'd1);

        // All four ports read the same word together.
        a_wr(32'd7, 32'hA5A5_5A5A, 4'hF); tick; a_idle;
        a_rd(0, 32'd7); a_rd(1, 32'd7); a_rd(2, 32'd7); a_rd(3, 32'd7);
        a_go;
        chk("quad_valid", 128'(rd_valid_a), 128'hF);
        chk("quad_data", rd_data_a, {4{32'hA5A5_5A5A}});

        // Small non-power-of-two instance, no fill, latency 1.
        wr_en_b = 1'b1; wr_addr_b = 8'd9; wr_data_b = 32'h0BAD_F00D; wr_be_b = 4'hF;
        tick;
        wr_en_b = 1'b0;
        chk("b_wr_ok", 128'(wr_err_b), 128'd0);
        rd_en_b = 1'b1; rd_addr_b = 8'd9;
        tick;
        rd_en_b = 1'b0;
        chk("b_rd_valid", 128'(rd_valid_b), 128'd1);
        chk("b_rd_data", 128'(rd_data_b), 128'h0BAD_F00D);
        rd_en_b = 1'b1; rd_addr_b = 8'd10;
        tick;
        rd_en_b = 1'b0;
        chk("b_oor_err", 128'(rd_err_b), 128'd1);
        chk("b_oor_data", 128'(rd_data_b), 128'd0);
        wr_en_b = 1'b1; wr_addr_b = 8'd10;
        tick;
        wr_en_b = 1'b0;
        chk("b_wr_err", 128'(wr_err_b), 128'd1);

        // Streaming reads with a reset pulse in the middle: in-flight reads are discarded.
        before_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_en_a = 4'b0011;
            rd_addr_a[31:0]  = 32'(i);
            rd_addr_a[63:32] = 32'(i + 1);
            rst_n = (i != 5);
            tick;
            if (i < 5) before_rst = before_rst | (|rd_valid_a);
            else       seen = seen | (|rd_valid_a);
            if (i == 5) chk("midrst_init_done", 128'(init_done_a), 128'd0);
        end
        a_idle;
        rst_n = 1'b1;
        n = 0;
        while (!init_done_a && n < 1000) begin
            tick;
            n++;
            seen = seen | (|rd_valid_a);
        end
        chk("midrst_before_valid", 128'(before_rst), 128'd1);
        chk("midrst_flushed", 128'(seen), 128'd0);
        chk("refill_cycles", 128'(n), 128'd252);
        a_rd(0, 32'd5);
        a_go;
        chk("refill_zero", 128'(rd_data_a[31:0]), 128'd0);
        chk("refill_valid", 128'(rd_valid_a), 128'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
